// File: rtl/lcd_hex_frame_writer_if.sv
// ---------------------------------------------------------------------------
// lcd_hex_frame_writer_if
// Purpose : 8-bit HD44780-class character LCD write bus.
// Signals : LCD_DATA  8  data / command byte
//           LCD_RW    1  read/write select (writer always drives 0)
//           LCD_EN    1  enable strobe
//           LCD_RS    1  0 = command, 1 = character
// Modports: master - the sequencer driving the panel
//           slave  - the panel (or a bus monitor)
// ---------------------------------------------------------------------------
interface lcd_hex_frame_writer_if;
    logic [7:0] LCD_DATA;
    logic       LCD_RW;
    logic       LCD_EN;
    logic       LCD_RS;

    modport master (output LCD_DATA, output LCD_RW, output LCD_EN, output LCD_RS);
    modport slave  (input  LCD_DATA, input  LCD_RW, input  LCD_EN, input  LCD_RS);
endinterface

// File: rtl/lcd_hex_frame_writer.sv
// ---------------------------------------------------------------------------
// lcd_hex_frame_writer
// Purpose : Writes NUM_LINES lines of hex bytes to an HD44780-class LCD.
//           Each line is "HH HH ... HH" padded with spaces to 16 columns.
//           After reset the panel is initialised once (0x38, 0x0C, 0x01,
//           0x06); frames then repeat continuously (iMODE=0) or on request
//           (iMODE=1). iDATA is snapshotted at each frame start.
// Ports   : iCLK, iRST     clock, asynchronous active-high reset
//           iDATA          packed bytes, byte k at [8k+7:8k],
//                          k = line*BYTES_PER_LINE + position
//           iMODE          0 = continuous refresh, 1 = refresh on iLOAD
//           iLOAD          one-cycle frame request (mode 1 only)
//           oBUSY          high during init and frames, low only in idle
//           oFRAME_DONE    one-cycle pulse after the last gap of a frame
//           lcd            LCD write bus (master side)
// ---------------------------------------------------------------------------
module lcd_hex_frame_writer #(
    parameter int NUM_LINES      = 2,
    parameter int BYTES_PER_LINE = 5,
    parameter int CLK_DIV        = 16,
    parameter int CHAR_DLY       = 2000,
    parameter int CLR_DLY        = 100000
) (
    input  logic                                  iCLK,
    input  logic                                  iRST,
    input  logic [8*NUM_LINES*BYTES_PER_LINE-1:0] iDATA,
    input  logic                                  iMODE,
    input  logic                                  iLOAD,
    output logic                                  oBUSY,
    output logic                                  oFRAME_DONE,
    lcd_hex_frame_writer_if.master                lcd
);

    localparam int NB    = NUM_LINES * BYTES_PER_LINE;
    localparam int MAXG  = (CLR_DLY > CHAR_DLY) ? CLR_DLY : CHAR_DLY;
    localparam int MAXD  = (MAXG > CLK_DIV) ? MAXG : CLK_DIV;
    localparam int CW    = $clog2(MAXD + 1);
    localparam logic [1:0] LN = 2'(NUM_LINES);
    localparam logic [2:0] LB = 3'(BYTES_PER_LINE);

    typedef enum logic [2:0] {
        ST_RESET,   // first cycle after reset release
        ST_INIT,    // panel init commands
        ST_FRAME,   // frame writes
        ST_DONE,    // frame-done pulse cycle, mode sampled here
        ST_IDLE     // waiting for a request (mode 1)
    } state_t;

    typedef enum logic [1:0] {
        PH_SETUP,
        PH_EN,
        PH_HOLD,
        PH_GAP
    } phase_t;

    state_t          r_st;
    phase_t          r_ph;
    logic [CW-1:0]   r_cnt;
    logic [2:0]      r_idx;     // next init command index
    // Frame position of the NEXT write to issue:
    //   r_col 0 = line address command, 1..16 = character columns
    //   r_j/r_sub = byte position and sub-slot (hi nibble, lo nibble, space)
    logic [1:0]      r_line;
    logic [4:0]      r_col;
    logic [2:0]      r_j;
    logic [1:0]      r_sub;
    logic [8*NB-1:0] r_snap;
    logic            r_pend;
    logic [7:0]      r_data;
    logic            r_rs;
    logic            r_en;
    logic            r_busy;
    logic            r_done;

    logic            w_gap_end;
    logic            w_req;
    logic            w_start;
    int              w_k;
    logic [7:0]      w_byte;
    logic [3:0]      w_nib;
    logic [7:0]      w_hex;
    logic [7:0]      w_next_data;
    logic            w_next_rs;
    logic [CW-1:0]   w_gap_len;

    function automatic logic [7:0] init_cmd(input logic [2:0] i);
        case (i)
            3'd0:    return 8'h38;
            3'd1:    return 8'h0C;
            3'd2:    return 8'h01;
            3'd3:    return 8'h06;
            default: return 8'h00;
        endcase
    endfunction

    assign w_gap_end = (r_ph == PH_GAP) && (r_cnt == '0);

    // In continuous mode a frame is always wanted; in load mode a live
    // iLOAD or a request remembered while busy starts one.
    assign w_req = iMODE ? (iLOAD || r_pend) : 1'b1;

    assign w_start = ((r_st == ST_INIT) && w_gap_end && (r_idx == 3'd4)) ||
                     (((r_st == ST_DONE) || (r_st == ST_IDLE)) && w_req);

    // Pick the snapshot byte for the current line/position. Positions past
    // the line content never reach the output (they are padding), so an
    // out-of-range index just yields zero.
    always_comb begin
        w_byte = '0;
        w_k    = int'(r_line) * BYTES_PER_LINE + int'(r_j);
        for (int k = 0; k < NB; k++) begin
            if (w_k == k) w_byte = r_snap[8*k +: 8];
        end
    end

    assign w_nib = (r_sub == 2'd0) ? w_byte[7:4] : w_byte[3:0];
    assign w_hex = (w_nib < 4'd10) ? (8'h30 + {4'h0, w_nib}) : (8'h37 + {4'h0, w_nib});

    always_comb begin
        w_next_data = 8'h20;
        w_next_rs   = 1'b1;
        if (r_col == 5'd0) begin
            w_next_data = (r_line == 2'd0) ? 8'h80 : 8'hC0;
            w_next_rs   = 1'b0;
        end else if ((r_j < LB) && (r_sub != 2'd2)) begin
            w_next_data = w_hex;
        end
    end

    // Clear display needs the long settle time; every other write the short one.
    assign w_gap_len = ((r_data == 8'h01) && !r_rs) ? CW'(CLR_DLY - 1) : CW'(CHAR_DLY - 1);

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            r_st   <= ST_RESET;
            r_ph   <= PH_SETUP;
            r_cnt  <= '0;
            r_idx  <= '0;
            r_line <= '0;
            r_col  <= '0;
            r_j    <= '0;
            r_sub  <= '0;
            r_snap <= '0;
            r_pend <= 1'b0;
            r_data <= 8'h00;
            r_rs   <= 1'b0;
            r_en   <= 1'b0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (iLOAD && iMODE) r_pend <= 1'b1;

            case (r_st)
                ST_RESET: begin
                    r_busy <= 1'b1;
                    r_data <= init_cmd(3'd0);
                    r_rs   <= 1'b0;
                    r_idx  <= 3'd1;
                    r_ph   <= PH_SETUP;
                    r_st   <= ST_INIT;
                end

                ST_INIT, ST_FRAME: begin
                    case (r_ph)
                        PH_SETUP: begin
                            r_ph  <= PH_EN;
                            r_en  <= 1'b1;
                            r_cnt <= CW'(CLK_DIV - 1);
                        end
                        PH_EN: begin
                            if (r_cnt == '0) begin
                                r_ph  <= PH_HOLD;
                                r_en  <= 1'b0;
                                r_cnt <= CW'(CLK_DIV - 1);
                            end else begin
                                r_cnt <= r_cnt - 1'b1;
                            end
                        end
                        PH_HOLD: begin
                            if (r_cnt == '0) begin
                                r_ph  <= PH_GAP;
                                r_cnt <= w_gap_len;
                            end else begin
                                r_cnt <= r_cnt - 1'b1;
                            end
                        end
                        PH_GAP: begin
                            if (r_cnt != '0) begin
                                r_cnt <= r_cnt - 1'b1;
                            end else if (r_st == ST_INIT) begin
                                // After the last command the frame start below takes over.
                                if (r_idx != 3'd4) begin
                                    r_data <= init_cmd(r_idx);
                                    r_rs   <= 1'b0;
                                    r_idx  <= r_idx + 1'b1;
                                    r_ph   <= PH_SETUP;
                                end
                            end else if (r_line == LN) begin
                                r_st   <= ST_DONE;
                                r_done <= 1'b1;
                            end else begin
                                r_data <= w_next_data;
                                r_rs   <= w_next_rs;
                                r_ph   <= PH_SETUP;
                                if (r_col == 5'd16) begin
                                    r_col  <= '0;
                                    r_line <= r_line + 1'b1;
                                    r_j    <= '0;
                                    r_sub  <= '0;
                                end else begin
                                    r_col <= r_col + 1'b1;
                                    // The address slot does not consume a character position.
                                    if (r_col != 5'd0) begin
                                        if (r_sub == 2'd2) begin
                                            r_sub <= '0;
                                            r_j   <= r_j + 1'b1;
                                        end else begin
                                            r_sub <= r_sub + 1'b1;
                                        end
                                    end
                                end
                            end
                        end
                        default: r_ph <= PH_SETUP;
                    endcase
                end

                ST_DONE: begin
                    if (!w_req) begin
                        r_st   <= ST_IDLE;
                        r_busy <= 1'b0;
                    end
                end

                ST_IDLE: begin
                end

                default: r_st <= ST_RESET;
            endcase

            // Frame start overrides whatever the state logic chose this cycle:
            // snapshot the data, drop any pending request and put the line-0
            // address on the bus in SETUP.
            if (w_start) begin
                r_st   <= ST_FRAME;
                r_busy <= 1'b1;
                r_snap <= iDATA;
                r_pend <= 1'b0;
                r_data <= 8'h80;
                r_rs   <= 1'b0;
                r_ph   <= PH_SETUP;
                r_line <= '0;
                r_col  <= 5'd1;
                r_j    <= '0;
                r_sub  <= '0;
            end
        end
    end

    assign lcd.LCD_DATA = r_data;
    assign lcd.LCD_RW   = 1'b0;
    assign lcd.LCD_EN   = r_en;
    assign lcd.LCD_RS   = r_rs;
    assign oBUSY        = r_busy;
    assign oFRAME_DONE  = r_done;

endmodule

// File: tb/tb_lcd_hex_frame_writer.sv
// ---------------------------------------------------------------------------
// tb_lcd_hex_frame_writer
// Bench for lcd_hex_frame_writer with small timing parameters. A bus monitor
// records every write (RS, DATA, cycle of EN rise); expected frames are built
// from the display rules with plain string-style arithmetic.
// ---------------------------------------------------------------------------
module tb_lcd_hex_frame_writer;
    localparam int NL  = 2;
    localparam int BPL = 2;
    localparam int CD  = 2;
    localparam int CHD = 3;
    localparam int CLD = 10;
    localparam int DW  = 8 * NL * BPL;
    localparam int FW  = NL * 17;

    logic          iCLK  = 1'b0;
    logic          iRST  = 1'b0;
    logic [DW-1:0] iDATA = '0;
    logic          iMODE = 1'b0;
    logic          iLOAD = 1'b0;
    logic          oBUSY;
    logic          oFRAME_DONE;

    lcd_hex_frame_writer_if lcd();

    lcd_hex_frame_writer #(
        .NUM_LINES(NL), .BYTES_PER_LINE(BPL), .CLK_DIV(CD),
        .CHAR_DLY(CHD), .CLR_DLY(CLD)
    ) dut (
        .iCLK(iCLK), .iRST(iRST), .iDATA(iDATA), .iMODE(iMODE), .iLOAD(iLOAD),
        .oBUSY(oBUSY), .oFRAME_DONE(oFRAME_DONE), .lcd(lcd)
    );

    always #5 iCLK = ~iCLK;

    int cyc = 0;
    always @(posedge iCLK) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    endtask

    // ---------------- bus monitor ----------------
    logic [8:0] wq[$];
    int         wr[$];
    int         n_done   = 0;
    int         done_cyc = 0;
    logic       prev_en  = 1'b0;
    int         en_cnt   = 0;
    logic [8:0] rise_val = '0;

    always @(negedge iCLK) begin
        if (lcd.LCD_EN && !prev_en) begin
            wq.push_back({lcd.LCD_RS, lcd.LCD_DATA});
            wr.push_back(cyc);
            en_cnt   <= 1;
            rise_val <= {lcd.LCD_RS, lcd.LCD_DATA};
        end else if (lcd.LCD_EN) begin
            en_cnt <= en_cnt + 1;
        end else if (prev_en && !iRST) begin
            chk("en_len", 32'(en_cnt), 32'(CD));
            chk("bus_stable", 32'({lcd.LCD_RS, lcd.LCD_DATA}), 32'(rise_val));
        end
        if (oFRAME_DONE) begin
            n_done   <= n_done + 1;
            done_cyc <= cyc;
        end
        prev_en <= lcd.LCD_EN;
    end

    // ---------------- reference model ----------------
    logic [8:0] expf[FW];

    function automatic logic [7:0] hexc(input logic [3:0] n);
        if (n < 4'd10) return 8'd48 + {4'd0, n};       // '0'..'9'
        else           return 8'd65 + {4'd0, n} - 8'd10; // 'A'..'F'
    endfunction

    task automatic build_frame(input logic [DW-1:0] d);
        logic [7:0] s[$];
        logic [7:0] b;
        for (int L = 0; L < NL; L++) begin
            s.delete();
            for (int j = 0; j < BPL; j++) begin
                b = d[8*(L*BPL+j) +: 8];
                s.push_back(hexc(b[7:4]));
                s.push_back(hexc(b[3:0]));
                if (j < BPL - 1) s.push_back(8'h20);
            end
            while (s.size() < 16) s.push_back(8'h20);
            expf[L*17] = {1'b0, (L == 0) ? 8'h80 : 8'hC0};
            for (int c = 0; c < 16; c++) expf[L*17+1+c] = {1'b1, s[c]};
        end
    endtask

    task automatic check_frame(input int base, input string tag);
        logic [8:0] got;
        for (int i = 0; i < FW; i++) begin
            got = (base + i < wq.size()) ? wq[base+i] : 9'h1FF;
            chk($sformatf("%s[%0d]", tag, i), 32'(got), 32'(expf[i]));
        end
    endtask

    task automatic tick();
        @(negedge iCLK);
        #1;
    endtask

    task automatic wait_writes(input int n, input int budget);
        int t = 0;
        while (wq.size() < n && t < budget) begin
            tick();
            t++;
        end
        chk("wait_writes", 32'(wq.size() >= n), 32'd1);
    endtask

    task automatic pulse_load();
        iLOAD = 1'b1;
        tick();
        iLOAD = 1'b0;
    endtask

    function automatic logic [DW-1:0] rnd();
        logic [DW-1:0] r;
        for (int k = 0; k < DW/8; k++) r[8*k +: 8] = 8'($urandom);
        return r;
    endfunction

    task automatic check_init(input string tag);
        logic [7:0] icmd[4];
        int         gap;
        icmd = '{8'h38, 8'h0C, 8'h01, 8'h06};
        for (int i = 0; i < 4; i++) begin
            chk({tag, "_cmd"}, 32'(wq[i]), 32'({1'b0, icmd[i]}));
            gap = (icmd[i] == 8'h01) ? CLD : CHD;
            chk({tag, "_period"}, 32'(wr[i+1] - wr[i]), 32'(1 + 2*CD + gap));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        logic [DW-1:0] d1, d2, d3, dc;
        int base, nw, nd0, t;

        // ---- reset and init ----
        iRST  = 1'b1;
        iMODE = 1'b0;
        iDATA = 32'hFE003FA5;
        repeat (3) tick();
        chk("rst_data", 32'(lcd.LCD_DATA), 32'h0);
        chk("rst_en",   32'(lcd.LCD_EN),   32'h0);
        chk("rst_rs",   32'(lcd.LCD_RS),   32'h0);
        chk("rst_rw",   32'(lcd.LCD_RW),   32'h0);
        chk("rst_busy", 32'(oBUSY),        32'h0);
        chk("rst_done", 32'(oFRAME_DONE),  32'h0);
        iRST = 1'b0;
        tick();
        chk("rel_busy",  32'(oBUSY), 32'h1);
        chk("rel_setup", 32'({lcd.LCD_EN, lcd.LCD_RS, lcd.LCD_DATA}), 32'h038);
        wait_writes(5, 200);
        check_init("init");

        // ---- continuous mode, fixed pattern ----
        base = 4;
        wait_writes(base + FW, 400);
        build_frame(32'hFE003FA5);
        check_frame(base, "f1");
        wait_writes(base + FW + 1, 100);
        chk("f1_done_cnt", 32'(n_done), 32'd1);
        chk("f1_done_cyc", 32'(done_cyc), 32'(wr[base+FW-1] + 2*CD + CHD));
        chk("f2_addr",     32'(wq[base+FW]), 32'h080);
        chk("f2_restart",  32'(wr[base+FW] - wr[base+FW-1]), 32'(2*CD + CHD + 2));
        // A load in continuous mode must not leave a request behind.
        pulse_load();
        repeat (3) tick();
        iMODE = 1'b1;
        base = base + FW;
        wait_writes(base + FW, 400);
        check_frame(base, "f2");

        // ---- load mode: idle, then single load ----
        repeat (30) tick();
        chk("idle_done_cnt", 32'(n_done), 32'd2);
        chk("idle_busy", 32'(oBUSY), 32'h0);
        nw = wq.size();
        repeat (20) tick();
        chk("idle_static", 32'(wq.size()), 32'(nw));
        chk("idle_en",     32'(lcd.LCD_EN), 32'h0);
        chk("idle_hold",   32'({lcd.LCD_RS, lcd.LCD_DATA}), 32'h120);
        d1 = rnd();
        iDATA = d1;
        pulse_load();
        chk("load_setup", 32'({lcd.LCD_EN, lcd.LCD_RS, lcd.LCD_DATA}), 32'h080);
        chk("load_busy",  32'(oBUSY), 32'h1);
        iDATA = rnd();
        base = wq.size();
        build_frame(d1);
        wait_writes(base + FW, 400);
        check_frame(base, "f3");

        // ---- load mode: several requests mid-frame collapse to one ----
        repeat (30) tick();
        chk("f3_idle", 32'(oBUSY), 32'h0);
        nd0 = n_done;
        d1 = rnd();
        iDATA = d1;
        pulse_load();
        base = wq.size();
        wait_writes(base + 10, 200);
        d2 = rnd();
        iDATA = d2;
        for (int p = 0; p < 3; p++) begin
            pulse_load();
            repeat (5) tick();
        end
        wait_writes(base + FW + 2, 400);
        d3 = rnd();
        iDATA = d3;
        wait_writes(base + 2*FW, 400);
        repeat (40) tick();
        build_frame(d1);
        check_frame(base, "fa");
        build_frame(d2);
        check_frame(base + FW, "fb");
        chk("collapse_writes", 32'(wq.size()), 32'(base + 2*FW));
        chk("collapse_done",   32'(n_done - nd0), 32'd2);
        chk("collapse_busy",   32'(oBUSY), 32'h0);

        // ---- load on the frame-done cycle, 9/A hex boundary ----
        dc = rnd();
        dc[7:0] = 8'h9A;
        iDATA = dc;
        pulse_load();
        base = wq.size();
        t = 0;
        while (!oFRAME_DONE && t < 500) begin
            tick();
            t++;
        end
        chk("done_seen", 32'(oFRAME_DONE), 32'h1);
        iLOAD = 1'b1;
        tick();
        iLOAD = 1'b0;
        chk("b2b_setup", 32'({lcd.LCD_EN, lcd.LCD_RS, lcd.LCD_DATA}), 32'h080);
        chk("b2b_busy",  32'(oBUSY), 32'h1);
        chk("b2b_pulse", 32'(oFRAME_DONE), 32'h0);
        wait_writes(base + 2*FW, 400);
        build_frame(dc);
        check_frame(base, "fc");
        check_frame(base + FW, "fd");
        chk("hex_9", 32'(wq[base+1]), 32'h139);
        chk("hex_A", 32'(wq[base+2]), 32'h141);
        repeat (40) tick();
        chk("fd_idle", 32'(wq.size()), 32'(base + 2*FW));

        // ---- asynchronous reset during EN high ----
        pulse_load();
        t = 0;
        while (!lcd.LCD_EN && t < 50) begin
            tick();
            t++;
        end
        chk("en_seen", 32'(lcd.LCD_EN), 32'h1);
        #1 iRST = 1'b1;
        #1;
        chk("async_en",   32'(lcd.LCD_EN), 32'h0);
        chk("async_busy", 32'(oBUSY),      32'h0);
        chk("async_data", 32'(lcd.LCD_DATA), 32'h0);
        repeat (3) tick();
        wq.delete();
        wr.delete();
        nd0 = n_done;
        d1 = rnd();
        iDATA = d1;
        iRST = 1'b0;
        tick();
        chk("rerun_setup", 32'({lcd.LCD_EN, lcd.LCD_RS, lcd.LCD_DATA}), 32'h038);
        wait_writes(4 + FW, 500);
        check_init("reinit");
        build_frame(d1);
        check_frame(4, "fr");
        repeat (40) tick();
        chk("rerun_idle_w", 32'(wq.size()), 32'(4 + FW));
        chk("rerun_done",   32'(n_done - nd0), 32'd1);
        chk("rerun_busy",   32'(oBUSY), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/lcd_hex_frame_writer.md
Name: lcd_hex_frame_writer

Overview:
- Parametrised successor to the fixed 2x16 hex-dump LCD sequencer.
- Drives an HD44780-class character LCD over an 8-bit bus, with internal bus timing and no separate controller.
- Shows NUM_LINES lines, each holding BYTES_PER_LINE hex bytes separated by spaces and space-padded to 16 columns.
- Supports continuous refresh or refresh-on-load, captures a data snapshot per frame, and reports busy and frame-done status to the host logic.

Parameters:
- NUM_LINES, 2, number of display lines written; 1 or 2 only. Line 1 address is 0x80, line 2 address is 0xC0.
- BYTES_PER_LINE, 5, hex bytes per line; 1..5. Line content is 3*BYTES_PER_LINE-1 chars.
- CLK_DIV, 16, cycles LCD_EN is high, and cycles data is held after EN falls; >=1.
- CHAR_DLY, 2000, idle gap in cycles after every write except Clear; >=1.
- CLR_DLY, 100000, idle gap in cycles after the Clear command (0x01); >=1.

Ports:
- iCLK  in  1  clock.
- iRST  in  1  asynchronous active-high reset.
- iDATA  in  8*NUM_LINES*BYTES_PER_LINE  packed bytes. Byte k is at [8k+7:8k]. Line L, position j uses k = L*BYTES_PER_LINE+j.
- iMODE  in  1  0 = continuous refresh, 1 = refresh only on iLOAD.
- iLOAD  in  1  single-cycle frame request; used only when iMODE=1.
- oBUSY  out  1  high while the init sequence or a frame is in progress.
- oFRAME_DONE  out  1  one-cycle pulse after the last gap of a frame.
- LCD_DATA  out  8  LCD data bus.
- LCD_RW  out  1  constant 0 (write only).
- LCD_EN  out  1  LCD enable strobe.
- LCD_RS  out  1  0 = command, 1 = character.

Behaviour:
- Reset values: LCD_DATA=0, LCD_EN=0, LCD_RS=0, LCD_RW=0, oBUSY=0, oFRAME_DONE=0. All internal state returns to INIT, and the pending flag and snapshot are cleared.
- Reset is asynchronous. Asserting it mid-write forces LCD_EN low immediately, and the full init sequence restarts after release.
- Write cycle (every byte), total 1+2*CLK_DIV+gap cycles:
  - SETUP: 1 cycle, RS/DATA valid, EN=0.
  - EN_HI: CLK_DIV cycles, EN=1.
  - HOLD: CLK_DIV cycles, EN=0, RS/DATA unchanged.
  - GAP: CHAR_DLY cycles, or CLR_DLY cycles after command 0x01.
- INIT: commands 0x38, 0x0C, 0x01, 0x06 (RS=0), issued once after reset. Never repeated between frames.
- oBUSY is 1 from the first cycle after reset release through the end of INIT.
- States: INIT -> FRAME -> IDLE -> FRAME...
- Frame start, mode 0: entered immediately after INIT and after every frame end.
- Frame start, mode 1:
  - Entered from IDLE when iLOAD=1, or when the pending flag is set.
  - First frame after INIT occurs without iLOAD.
  - SETUP of the first frame command follows iLOAD by 1 cycle.
- Snapshot: iDATA is registered on the frame-start cycle. Changes to iDATA during a frame do not affect that frame.
- Frame contents, per line L:
  - Address command (RS=0): 0x80 for L=0, 0xC0 for L=1.
  - For each byte: high nibble char, low nibble char, then 0x20 except after the last byte of the line.
  - 0x20 pad chars up to 16 characters total.
  - All characters use RS=1.
- Hex encoding: nibble 0-9 maps to 0x30+n; nibble A-F maps to 0x37+n (uppercase).
- Frame end: oFRAME_DONE pulses for 1 cycle on the cycle after the final GAP. iMODE is sampled on that same cycle.
- oBUSY=1 throughout a frame. It is 0 in IDLE only.
- iLOAD while busy in mode 1 sets the pending flag; multiple requests collapse to one. The flag is consumed at the next frame start.
- iLOAD in mode 0 is ignored.
- Simultaneous frame end and iLOAD: the request counts, and the next frame starts immediately.
- IDLE: LCD_EN=0, and LCD_DATA/LCD_RS hold their last values.

Test Plan:
Bench parameters: NUM_LINES=2, BYTES_PER_LINE=2, CLK_DIV=2, CHAR_DLY=3, CLR_DLY=10.
1. Reset pulse, then release -> bus shows 0x38, 0x0C, 0x01, 0x06 with RS=0. Each write is 8 cycles, except 0x01 at 15 cycles. Each EN high lasts exactly 2 cycles.
2. iMODE=0, iDATA bytes 0=0xA5, 1=0x3F, 2=0x00, 3=0xFE -> writes 0x80, 41 35 20 33 46, then 11x 0x20; then 0xC0, 30 30 20 46 45, then 11x 0x20. oFRAME_DONE pulses once, and the next frame starts with 0x80 and no init.
3. iMODE=1 after the first frame -> IDLE with oBUSY=0 and EN static. A 1-cycle iLOAD -> 0x80 appears in SETUP 1 cycle later, and oBUSY=1.
4. Mode 1: 3 iLOAD pulses mid-frame, with iDATA changed mid-frame -> the current frame shows the old data, then exactly one more frame shows the new data, then IDLE.
5. Assert iRST while LCD_EN=1 -> LCD_EN=0 in the same cycle, with no clock edge required. After release, init restarts at 0x38.
6. iDATA byte 0=0x9A -> chars 0x39, 0x41, covering the 9/A encoding boundary.
